// File: rtl/window_gen_3x3.sv
// -----------------------------------------------------------------------------
// window_gen_3x3
//   Streaming 3x3 neighbourhood generator for the SIFT front end. Raster-order
//   pixels arrive one per in_valid beat. Two line buffers keep the two previous
//   rows, and a 3x3 register window slides one column per beat. Every beat that
//   carries pixel (r,c) with r>=2 and c>=2 completes the window centred at
//   (r-1,c-1). That window is presented, registered, in the following cycle.
//
// Ports
//   clk        rising-edge clock
//   rst_n      asynchronous active-low reset
//   in_valid   in_data carries the next raster pixel this cycle
//   in_data    unsigned pixel, DW bits
//   out_valid  out_win/out_row/out_col are valid this cycle
//   out_win    out_win[(3*i+j)*DW +: DW] = pixel(out_row-1+i, out_col-1+j)
//   out_row    centre row of the window (1..ROWS-2)
//   out_col    centre column of the window (1..COLS-2)
//   out_eof    raised with the last window of the frame
// -----------------------------------------------------------------------------
module window_gen_3x3 #(
    parameter int COLS = 640,
    parameter int ROWS = 480,
    parameter int DW   = 8
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            in_valid,
    input  logic [DW-1:0]   in_data,
    output logic            out_valid,
    output logic [9*DW-1:0] out_win,
    output logic [9:0]      out_row,
    output logic [9:0]      out_col,
    output logic            out_eof
);

    localparam int         AW       = $clog2(COLS);
    localparam logic [9:0] COL_LAST = 10'(COLS - 1);
    localparam logic [9:0] ROW_LAST = 10'(ROWS - 1);

    // Line buffers: lb1 holds row r-1, lb0 holds row r-2 relative to the
    // incoming row r. Their contents need no reset.
    logic [DW-1:0] lb0_q [0:COLS-1];
    logic [DW-1:0] lb1_q [0:COLS-1];
    logic [DW-1:0] lb0_rd_s;
    logic [DW-1:0] lb1_rd_s;

    // Raster position of the pixel expected on the next beat.
    logic [9:0] col_q, col_d;
    logic [9:0] row_q, row_d;

    // Sliding window, packed in the same lane order as out_win.
    logic [9*DW-1:0] win_q, win_d;

    logic            out_valid_q, out_valid_d;
    logic [9*DW-1:0] out_win_q,   out_win_d;
    logic [9:0]      out_row_q,   out_row_d;
    logic [9:0]      out_col_q,   out_col_d;
    logic            out_eof_q,   out_eof_d;

    // Next-state logic: counters, window shift and the emit decision.
    always_comb begin
        lb0_rd_s    = lb0_q[col_q[AW-1:0]];
        lb1_rd_s    = lb1_q[col_q[AW-1:0]];
        col_d       = col_q;
        row_d       = row_q;
        win_d       = win_q;
        out_valid_d = 1'b0;
        out_eof_d   = 1'b0;
        out_win_d   = out_win_q;
        out_row_d   = out_row_q;
        out_col_d   = out_col_q;

        if (in_valid) begin
            // Every window row moves one column to the left.
            for (int i = 0; i < 3; i++) begin
                win_d[(3*i)*DW   +: DW] = win_q[(3*i+1)*DW +: DW];
                win_d[(3*i+1)*DW +: DW] = win_q[(3*i+2)*DW +: DW];
            end
            // The new right column, from top to bottom, is rows r-2, r-1 and r.
            win_d[2*DW +: DW] = lb0_rd_s;
            win_d[5*DW +: DW] = lb1_rd_s;
            win_d[8*DW +: DW] = in_data;

            if (col_q == COL_LAST) begin
                col_d = 10'd0;
                if (row_q == ROW_LAST) begin
                    row_d = 10'd0;
                end else begin
                    row_d = row_q + 10'd1;
                end
            end else begin
                col_d = col_q + 10'd1;
            end

            // With c>=2 the shifted window spans columns c-2..c of a single
            // row band. A window that would straddle a row wrap is never emitted.
            if ((row_q >= 10'd2) && (col_q >= 10'd2)) begin
                out_valid_d = 1'b1;
                out_win_d   = win_d;
                out_row_d   = row_q - 10'd1;
                out_col_d   = col_q - 10'd1;
                out_eof_d   = (row_q == ROW_LAST) && (col_q == COL_LAST);
            end else begin
                out_valid_d = 1'b0;
            end
        end else begin
            win_d = win_q;
        end
    end

    // State and output registers with asynchronous reset.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            col_q       <= 10'd0;
            row_q       <= 10'd0;
            win_q       <= {(9*DW){1'b0}};
            out_valid_q <= 1'b0;
            out_win_q   <= {(9*DW){1'b0}};
            out_row_q   <= 10'd0;
            out_col_q   <= 10'd0;
            out_eof_q   <= 1'b0;
        end else begin
            col_q       <= col_d;
            row_q       <= row_d;
            win_q       <= win_d;
            out_valid_q <= out_valid_d;
            out_win_q   <= out_win_d;
            out_row_q   <= out_row_d;
            out_col_q   <= out_col_d;
            out_eof_q   <= out_eof_d;
        end
    end

    // Line-buffer update. The combinational read above sees the old contents,
    // so a read and a write to the same address in one cycle return old data.
    always_ff @(posedge clk) begin
        if (in_valid) begin
            lb0_q[col_q[AW-1:0]] <= lb1_rd_s;
            lb1_q[col_q[AW-1:0]] <= in_data;
        end
    end

    assign out_valid = out_valid_q;
    assign out_win   = out_win_q;
    assign out_row   = out_row_q;
    assign out_col   = out_col_q;
    assign out_eof   = out_eof_q;

endmodule

// File: tb/tb_window_gen_3x3.sv
// -----------------------------------------------------------------------------
// tb_window_gen_3x3
//   Directed bench for window_gen_3x3 with COLS=8, ROWS=6, DW=8. The bench keeps
//   its own raster position and, for each accepted beat, derives the expected
//   window straight from the pixel pattern formula.
// -----------------------------------------------------------------------------
module tb_window_gen_3x3;

    localparam int COLS = 8;
    localparam int ROWS = 6;
    localparam int DW   = 8;

    logic            clk;
    logic            rst_n;
    logic            in_valid;
    logic [DW-1:0]   in_data;
    logic            out_valid;
    logic [9*DW-1:0] out_win;
    logic [9:0]      out_row;
    logic [9:0]      out_col;
    logic            out_eof;

    int n_assert = 0;
    int n_fail   = 0;
    int r        = 0;
    int c        = 0;
    int win_cnt  = 0;

    window_gen_3x3 #(.COLS(COLS), .ROWS(ROWS), .DW(DW)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_data   (in_data),
        .out_valid (out_valid),
        .out_win   (out_win),
        .out_row   (out_row),
        .out_col   (out_col),
        .out_eof   (out_eof)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Pixel patterns: 0 ramp, 1 inverted ramp, 2 all ones, 3 all zeros.
    function automatic logic [7:0] pix(input int pat, input int rr, input int cc);
        case (pat)
            0:       return 8'(16 * rr + cc);
            1:       return 8'(255 - (16 * rr + cc));
            2:       return 8'hFF;
            default: return 8'h00;
        endcase
    endfunction

    task automatic chk(input string tag, input logic [71:0] obs, input logic [71:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic chk_zero_outputs(input string tag);
        chk({tag, "_valid"}, 72'(out_valid), 72'd0);
        chk({tag, "_win"},   out_win,        72'd0);
        chk({tag, "_row"},   72'(out_row),   72'd0);
        chk({tag, "_col"},   72'(out_col),   72'd0);
        chk({tag, "_eof"},   72'(out_eof),   72'd0);
    endtask

    // One clock cycle: drive a beat (or an idle cycle) and check the result.
    task automatic step(input bit v, input int pat);
        logic [71:0] ew;
        @(negedge clk);
        in_valid = v;
        in_data  = v ? pix(pat, r, c) : 8'($urandom);
        @(posedge clk);
        #1;
        if (v && (r >= 2) && (c >= 2)) begin
            ew = 72'd0;
            for (int i = 0; i < 3; i++) begin
                for (int j = 0; j < 3; j++) begin
                    ew[(3*i+j)*8 +: 8] = pix(pat, r - 2 + i, c - 2 + j);
                end
            end
            chk("valid", 72'(out_valid), 72'd1);
            chk("win",   out_win,        ew);
            chk("row",   72'(out_row),   72'(r - 1));
            chk("col",   72'(out_col),   72'(c - 1));
            chk("eof",   72'(out_eof),   ((r == ROWS - 1) && (c == COLS - 1)) ? 72'd1 : 72'd0);
            win_cnt++;
            if (pat == 0 && r == 2 && c == 2) begin
                chk("first_win", out_win, 72'h222120121110020100);
            end
            if (pat == 0 && r == 3 && c == 2) begin
                chk("row_edge_left", out_win, 72'h323130222120121110);
            end
            if (pat == 0 && r == 2 && c == 7) begin
                chk("row_edge_right", out_win, 72'h272625171615070605);
            end
        end else begin
            chk("no_valid", 72'(out_valid), 72'd0);
            chk("no_eof",   72'(out_eof),   72'd0);
        end
        if (v) begin
            if (c == COLS - 1) begin
                c = 0;
                r = (r == ROWS - 1) ? 0 : r + 1;
            end else begin
                c = c + 1;
            end
        end
    endtask

    // A full frame of ROWS*COLS beats with roughly idle_pct percent idle cycles.
    task automatic frame(input int pat, input int idle_pct);
        int beats;
        beats   = 0;
        win_cnt = 0;
        while (beats < ROWS * COLS) begin
            if ($urandom_range(0, 99) < idle_pct) begin
                step(1'b0, pat);
            end else begin
                step(1'b1, pat);
                beats++;
            end
        end
        chk("win_count", 72'(win_cnt), 72'((ROWS - 2) * (COLS - 2)));
    endtask

    initial begin
        rst_n    = 1'b0;
        in_valid = 1'b0;
        in_data  = 8'h00;
        repeat (2) @(posedge clk);
        #1;
        chk_zero_outputs("reset");
        @(negedge clk);
        rst_n = 1'b1;

        // Continuous frame.
        frame(0, 0);
        // Same frame with idle gaps.
        frame(0, 40);
        // Back-to-back frames, the second with the inverted ramp.
        frame(0, 0);
        frame(1, 0);

        // Reset in the middle of row 3, then a fresh frame.
        win_cnt = 0;
        while (!(r == 3 && c == 3)) begin
            step(1'b1, 0);
        end
        @(negedge clk);
        rst_n    = 1'b0;
        in_valid = 1'b1;
        #1;
        chk_zero_outputs("async_rst");
        repeat (2) begin
            @(posedge clk);
            #1;
            chk_zero_outputs("rst_hold");
        end
        @(negedge clk);
        rst_n    = 1'b1;
        in_valid = 1'b0;
        r        = 0;
        c        = 0;
        frame(0, 20);

        // Extreme values.
        frame(2, 0);
        frame(3, 10);

        // A few idle cycles after the last frame must stay quiet.
        repeat (3) step(1'b0, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
